// File: rtl/axi4_lite_fanin_pkg.sv
// Shared types for the 2:1 AXI4-Lite fan-in.
//   wr_state_t : write-path FSM states
//   rd_state_t : read-path FSM states
//   rr_pick    : round-robin choice between two requesters
package axi4_lite_fanin_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    // If both ports request, the favoured port wins. If only one requests,
    // that port wins whatever the pointer says.
    function automatic logic rr_pick(input logic [NUM_PORTS-1:0] req, input logic favour);
        if (req == 2'b11) begin
            return favour;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/axi4_lite_rr_arbiter.sv
// Two-way round-robin arbiter with a registered grant.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   req_i       : request per port
//   advance_i   : take a new decision this cycle
//   grant_o     : registered one-hot grant
//   grant_idx_o : registered grant index
// The pointer rotates when the grant is taken rather than at completion.
// Only one transaction is outstanding per path, so the next decision sees
// the same priority either way.
module axi4_lite_rr_arbiter
    import axi4_lite_fanin_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 advance_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic                 grant_idx_o
);

    logic                 favour_q, favour_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 idx_q, idx_d;
    logic                 pick;

    always_comb begin
        pick     = rr_pick(req_i, favour_q);
        favour_d = favour_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        if (advance_i && (|req_i)) begin
            idx_d    = pick;
            grant_d  = {pick, ~pick};
            favour_d = ~pick;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            favour_q <= 1'b0;
            grant_q  <= '0;
            idx_q    <= 1'b0;
        end else begin
            favour_q <= favour_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;

endmodule

// File: rtl/axi4_lite_fanin.sv
// 2:1 AXI4-Lite interconnect. Two upstream initiators (s_*, index 0/1)
// share one downstream target (m_*). Write and read paths are arbitrated
// independently, and each path has one transaction in flight.
//   aclk_i, areset_i : clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*  : upstream write channels, per port
//   s_ar*/s_r*       : upstream read channels, per port
//   m_*              : downstream target port
//
// state  | meaning
// W_IDLE | no write owner; grant chosen from this cycle's awvalid
// W_ADDR | AW/W of granted port routed to target until both handshake
// W_RESP | B routed back to granted port
// R_IDLE | no read owner; grant chosen from this cycle's arvalid
// R_ADDR | AR of granted port routed to target
// R_DATA | R routed back to granted port
module axi4_lite_fanin
    import axi4_lite_fanin_pkg::*;
#(
    parameter int A = 16,
    parameter int N = 4,
    parameter int I = 1
) (
    input  logic                            aclk_i,
    input  logic                            areset_i,
    // upstream write
    input  logic [NUM_PORTS-1:0]            s_awvalid_i,
    output logic [NUM_PORTS-1:0]            s_awready_o,
    input  logic [NUM_PORTS-1:0][A-1:0]     s_awaddr_i,
    input  logic [NUM_PORTS-1:0][I-1:0]     s_awid_i,
    input  logic [NUM_PORTS-1:0]            s_wvalid_i,
    output logic [NUM_PORTS-1:0]            s_wready_o,
    input  logic [NUM_PORTS-1:0][N*8-1:0]   s_wdata_i,
    input  logic [NUM_PORTS-1:0][N-1:0]     s_wstrb_i,
    output logic [NUM_PORTS-1:0]            s_bvalid_o,
    input  logic [NUM_PORTS-1:0]            s_bready_i,
    output logic [NUM_PORTS-1:0][1:0]       s_bresp_o,
    output logic [NUM_PORTS-1:0][I-1:0]     s_bid_o,
    // upstream read
    input  logic [NUM_PORTS-1:0]            s_arvalid_i,
    output logic [NUM_PORTS-1:0]            s_arready_o,
    input  logic [NUM_PORTS-1:0][A-1:0]     s_araddr_i,
    input  logic [NUM_PORTS-1:0][I-1:0]     s_arid_i,
    output logic [NUM_PORTS-1:0]            s_rvalid_o,
    input  logic [NUM_PORTS-1:0]            s_rready_i,
    output logic [NUM_PORTS-1:0][N*8-1:0]   s_rdata_o,
    output logic [NUM_PORTS-1:0][1:0]       s_rresp_o,
    output logic [NUM_PORTS-1:0][I-1:0]     s_rid_o,
    // downstream
    output logic                            m_awvalid_o,
    input  logic                            m_awready_i,
    output logic [A-1:0]                    m_awaddr_o,
    output logic [I-1:0]                    m_awid_o,
    output logic                            m_wvalid_o,
    input  logic                            m_wready_i,
    output logic [N*8-1:0]                  m_wdata_o,
    output logic [N-1:0]                    m_wstrb_o,
    input  logic                            m_bvalid_i,
    output logic                            m_bready_o,
    input  logic [1:0]                      m_bresp_i,
    input  logic [I-1:0]                    m_bid_i,
    output logic                            m_arvalid_o,
    input  logic                            m_arready_i,
    output logic [A-1:0]                    m_araddr_o,
    output logic [I-1:0]                    m_arid_o,
    input  logic                            m_rvalid_i,
    output logic                            m_rready_o,
    input  logic [N*8-1:0]                  m_rdata_i,
    input  logic [1:0]                      m_rresp_i,
    input  logic [I-1:0]                    m_rid_i
);

    wr_state_t            wr_state_q, wr_state_d;
    rd_state_t            rd_state_q, rd_state_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic                 wr_adv, rd_adv;
    logic [NUM_PORTS-1:0] wr_grant, rd_grant;
    logic                 wr_idx, rd_idx;
    logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;

    axi4_lite_rr_arbiter u_wr_arb (
        .clk_i       (aclk_i),
        .rst_i       (areset_i),
        .req_i       (s_awvalid_i),
        .advance_i   (wr_adv),
        .grant_o     (wr_grant),
        .grant_idx_o (wr_idx)
    );

    axi4_lite_rr_arbiter u_rd_arb (
        .clk_i       (aclk_i),
        .rst_i       (areset_i),
        .req_i       (s_arvalid_i),
        .advance_i   (rd_adv),
        .grant_o     (rd_grant),
        .grant_idx_o (rd_idx)
    );

    // Payload muxes are unconditional. Only the valid/ready signals are qualified by state.
    assign m_awaddr_o = s_awaddr_i[wr_idx];
    assign m_awid_o   = s_awid_i[wr_idx];
    assign m_wdata_o  = s_wdata_i[wr_idx];
    assign m_wstrb_o  = s_wstrb_i[wr_idx];
    assign m_araddr_o = s_araddr_i[rd_idx];
    assign m_arid_o   = s_arid_i[rd_idx];

    assign s_bresp_o  = {NUM_PORTS{m_bresp_i}};
    assign s_bid_o    = {NUM_PORTS{m_bid_i}};
    assign s_rdata_o  = {NUM_PORTS{m_rdata_i}};
    assign s_rresp_o  = {NUM_PORTS{m_rresp_i}};
    assign s_rid_o    = {NUM_PORTS{m_rid_i}};

    always_comb begin
        wr_state_d  = wr_state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        wr_adv      = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        b_hs        = 1'b0;
        m_awvalid_o = 1'b0;
        m_wvalid_o  = 1'b0;
        m_bready_o  = 1'b0;
        s_awready_o = '0;
        s_wready_o  = '0;
        s_bvalid_o  = '0;
        case (wr_state_q)
            W_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (|s_awvalid_i) begin
                    wr_adv     = 1'b1;
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                // A done flag masks its channel so a completed AW or W is not replayed downstream.
                m_awvalid_o = s_awvalid_i[wr_idx] & ~aw_done_q;
                m_wvalid_o  = s_wvalid_i[wr_idx] & ~w_done_q;
                s_awready_o = wr_grant & {NUM_PORTS{m_awready_i & ~aw_done_q}};
                s_wready_o  = wr_grant & {NUM_PORTS{m_wready_i & ~w_done_q}};
                aw_hs       = m_awvalid_o & m_awready_i;
                w_hs        = m_wvalid_o & m_wready_i;
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) wr_state_d = W_RESP;
            end
            W_RESP: begin
                m_bready_o = s_bready_i[wr_idx];
                s_bvalid_o = wr_grant & {NUM_PORTS{m_bvalid_i}};
                b_hs       = m_bvalid_i & m_bready_o;
                if (b_hs) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_adv      = 1'b0;
        ar_hs       = 1'b0;
        r_hs        = 1'b0;
        m_arvalid_o = 1'b0;
        m_rready_o  = 1'b0;
        s_arready_o = '0;
        s_rvalid_o  = '0;
        case (rd_state_q)
            R_IDLE: begin
                if (|s_arvalid_i) begin
                    rd_adv     = 1'b1;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                m_arvalid_o = s_arvalid_i[rd_idx];
                s_arready_o = rd_grant & {NUM_PORTS{m_arready_i}};
                ar_hs       = m_arvalid_o & m_arready_i;
                if (ar_hs) rd_state_d = R_DATA;
            end
            R_DATA: begin
                m_rready_o = s_rready_i[rd_idx];
                s_rvalid_o = rd_grant & {NUM_PORTS{m_rvalid_i}};
                r_hs       = m_rvalid_i & m_rready_o;
                if (r_hs) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

endmodule
